rv_decode_stage: RTL and testbench
==================================

# rv_decode_stage

Parametrised ID stage and ID/EX pipeline register for the 5-stage RISC-V core. It decodes the full RV32I integer subset (no FENCE/SYSTEM) into EX-stage control signals. It contains the architectural register file with write-to-read bypass and registers everything into EX after a 1-cycle latency. Over the current decode stage it adds a stall/hold, valid tracking, illegal-instruction detection, sized register files (RV32E), and the remaining ALU, shift, compare, LUI/AUIPC and unsigned-branch decodes.

## Interface
- XLEN, 32: datapath width (register file, pc, imm, operands).
- NREGS, 32: architectural registers, 16 or 32; RV32E when 16.
- BYPASS, 1: 1 = a same-cycle W-stage write is forwarded to the D-stage read.
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- validD  in  1  instrD holds a real instruction.
- stallD  in  1  hold the ID/EX register (hazard unit).
- flushE  in  1  insert a bubble into EX.
- regwriteW  in  1  W-stage write enable.
- rdW  in  5  W-stage destination.
- resultW  in  XLEN  W-stage write data.
- instrD  in  32  instruction.
- pcD, pc4D  in  XLEN  pc and pc+4 of instrD.
- validE, illegalE  out  1  EX valid; EX instruction illegal.
- regwriteE, memrwE, brunE, branchE, jumpE, aselE, bselE  out  1  controls. aselE: 1 = pc as ALU A. bselE: 1 = imm as ALU B.
- wbselE  out  2  00 mem, 01 alu, 10 pc4.
- ALUselE  out  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu, 10 passB.
- funct3E  out  3  instrD[14:12], used for load/store width and branch condition.
- rdE, rs1E, rs2E  out  5  register indices.
- rd1E, rd2E, imm_exE, pcE, pc4E  out  XLEN  operands, immediate, pcs.

## Operation
- R-type (0110011):
  - funct7 0000000 gives add/sll/slt/sltu/xor/srl/or/and.
  - funct7 0100000 gives sub (f3 000) or sra (f3 101).
  - Any other funct7/f3 combination is illegal.
- OP-IMM (0010011): same ALU map with imm and bsel=1; no subi.
  - slli needs imm[11:5]=0000000.
  - srli/srai need imm[11:5] of 0000000 or 0100000.
- Loads (0000011): f3 in {000,001,010,100,101}; ALU add, bsel=1, wbsel=00, regwrite=1.
- Stores (0100011): f3 in {000,001,010}; S-imm, memrw=1, regwrite=0.
- Branches (1100011): f3 in {000,001,100,101,110,111}; B-imm, branch=1, asel=1, bsel=1, ALU add (target). brun=1 for f3 110/111 only.
- JAL: J-imm, asel=1, bsel=1, jump=1, wbsel=10, regwrite=1.
- JALR: f3 must be 000; I-imm, bsel=1, jump=1, wbsel=10, regwrite=1.
- LUI: U-imm, bsel=1, ALU passB, wbsel=01, regwrite=1.
- AUIPC: U-imm, asel=1, bsel=1, ALU add, wbsel=01, regwrite=1.
- Immediates: all are sign-extended from instr[31] to XLEN; U-imm is {instr[31:12],12'b0} sign-extended.
- Illegal conditions:
  - Any of the encoding violations above, or any other opcode.
  - With NREGS=16, a used rs1/rs2/rd field with bit 4 set.
- An illegal instruction produces illegalE=1 with regwrite/memrw/branch/jump all 0. Other fields pass through.
- When validD=0, all control fields are 0 and illegalE=0.
- Register file:
  - NREGS entries, all cleared on reset.
  - Written at posedge when regwriteW && rdW!=0 && rdW<NREGS.
  - x0 always reads 0.
- Read bypass: with BYPASS=1, if regwriteW && rdW==rsX && rsX!=0, rdX reads resultW. With BYPASS=0, rdX reads the array; the hazard unit must cover the gap.

## Timing
- Reset: every E-stage output is 0, including validE and illegalE; the register file is all 0. Reset takes effect immediately and may occur mid-stream.
- ID/EX update priority at posedge:
  - flushE: all E outputs go to 0 (bubble: validE=0, no writes).
  - else stallD: all E outputs hold.
  - else capture the decoded D values.
- flushE wins over a simultaneous stallD.
- A register-file write still occurs during a stall or flush.
- Latency: D inputs appear on E outputs 1 cycle later.
- While held by a stall, rd1E/rd2E keep their captured values. They do not re-read the register file; forwarding in EX covers any write during the stall.

## Test plan
- Reset mid-stream: assert rst_n=0 asynchronously between edges → all E outputs 0 at once; after release, reading x5 returns 0.
- Bypass:
  - BYPASS=1: regwriteW=1, rdW=5, resultW=0xDEADBEEF, and `add x1,x5,x5` in D → next cycle rd1E=rd2E=0xDEADBEEF.
  - rdW=0 → x0 still reads 0.
- Decode sweep:
  - `srai x3,x4,3` → ALUselE=7, bselE=1, imm_exE=3.
  - `bltu` → branchE=1, brunE=1, aselE=1.
  - `lui x2,0x80000` → imm_exE=0x80000000, ALUselE=10.
  - `auipc` → aselE=1.
- Illegal detection:
  - Opcode 0001111 → illegalE=1, regwriteE=0.
  - R-type funct7=0100000 with f3=111 → illegalE=1.
  - NREGS=16: `addi x17,x0,1` → illegalE=1.
- Stall then flush:
  - Capture `sw`, then hold stallD 3 cycles while instrD changes → E outputs unchanged.
  - Then stallD=1 and flushE=1 together → validE=0, memrwE=0.

Source files
------------

// File: rtl/rv_decode_stage_if.sv
// D-stage inputs, W-stage write port and ID/EX outputs of the decode stage.
// master drives D/W and consumes E; slave is the decode stage itself.
interface rv_decode_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            validD;
  logic            stallD;
  logic            flushE;
  logic            regwriteW;
  logic [4:0]      rdW;
  logic [XLEN-1:0] resultW;
  logic [31:0]     instrD;
  logic [XLEN-1:0] pcD;
  logic [XLEN-1:0] pc4D;

  logic            validE;
  logic            illegalE;
  logic            regwriteE;
  logic            memrwE;
  logic            brunE;
  logic            branchE;
  logic            jumpE;
  logic            aselE;
  logic            bselE;
  logic [1:0]      wbselE;
  logic [3:0]      ALUselE;
  logic [2:0]      funct3E;
  logic [4:0]      rdE;
  logic [4:0]      rs1E;
  logic [4:0]      rs2E;
  logic [XLEN-1:0] rd1E;
  logic [XLEN-1:0] rd2E;
  logic [XLEN-1:0] imm_exE;
  logic [XLEN-1:0] pcE;
  logic [XLEN-1:0] pc4E;

  modport master (
    output validD, stallD, flushE, regwriteW, rdW, resultW, instrD, pcD, pc4D,
    input  validE, illegalE, regwriteE, memrwE, brunE, branchE, jumpE, aselE, bselE,
           wbselE, ALUselE, funct3E, rdE, rs1E, rs2E, rd1E, rd2E, imm_exE, pcE, pc4E
  );

  modport slave (
    input  validD, stallD, flushE, regwriteW, rdW, resultW, instrD, pcD, pc4D,
    output validE, illegalE, regwriteE, memrwE, brunE, branchE, jumpE, aselE, bselE,
           wbselE, ALUselE, funct3E, rdE, rs1E, rs2E, rd1E, rd2E, imm_exE, pcE, pc4E
  );
endinterface

// File: rtl/rv_decode_stage.sv
// RV32I/RV32E decode stage: control decode, register file with W->D bypass,
// and the ID/EX pipeline register with stall/flush.
module rv_decode_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter bit          BYPASS = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  rv_decode_stage_if.slave  io_bus
);

  localparam int unsigned AW    = $clog2(NREGS);
  localparam bit          RV32E = (NREGS == 16);

  localparam logic [6:0] OpReg   = 7'b0110011;
  localparam logic [6:0] OpImm   = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;

  localparam logic [3:0] AluAdd   = 4'd0;
  localparam logic [3:0] AluSub   = 4'd1;
  localparam logic [3:0] AluAnd   = 4'd2;
  localparam logic [3:0] AluOr    = 4'd3;
  localparam logic [3:0] AluXor   = 4'd4;
  localparam logic [3:0] AluSll   = 4'd5;
  localparam logic [3:0] AluSrl   = 4'd6;
  localparam logic [3:0] AluSra   = 4'd7;
  localparam logic [3:0] AluSlt   = 4'd8;
  localparam logic [3:0] AluSltu  = 4'd9;
  localparam logic [3:0] AluPassB = 4'd10;

  typedef struct packed {
    logic            valid;
    logic            illegal;
    logic            regwrite;
    logic            memrw;
    logic            brun;
    logic            branch;
    logic            jump;
    logic            asel;
    logic            bsel;
    logic [1:0]      wbsel;
    logic [3:0]      alusel;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } ex_t;

  logic [XLEN-1:0] r_rf [NREGS];
  ex_t             r_ex;
  ex_t             w_dec;

  logic [31:0]     w_instr;
  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [3:0]      w_alu_f3;
  logic [31:0]     w_imm32;
  logic            w_use_rd;
  logic            w_use_rs1;
  logic            w_use_rs2;
  logic            w_we;
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;

  assign w_instr = io_bus.instrD;
  assign w_op    = w_instr[6:0];
  assign w_rd    = w_instr[11:7];
  assign w_f3    = w_instr[14:12];
  assign w_rs1   = w_instr[19:15];
  assign w_rs2   = w_instr[24:20];
  assign w_f7    = w_instr[31:25];

  // Register file: x0 is never written; RV32E ignores writes to x16..x31.
  assign w_we = io_bus.regwriteW && (io_bus.rdW != 5'd0) && !(RV32E && io_bus.rdW[4]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf <= '{default: '0};
    end else if (w_we) begin
      r_rf[io_bus.rdW[AW-1:0]] <= io_bus.resultW;
    end
  end

  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    if (w_rs1 != 5'd0 && !(RV32E && w_rs1[4])) w_rd1 = r_rf[w_rs1[AW-1:0]];
    if (w_rs2 != 5'd0 && !(RV32E && w_rs2[4])) w_rd2 = r_rf[w_rs2[AW-1:0]];
    if (BYPASS && io_bus.regwriteW && io_bus.rdW == w_rs1 && w_rs1 != 5'd0) begin
      w_rd1 = io_bus.resultW;
    end
    if (BYPASS && io_bus.regwriteW && io_bus.rdW == w_rs2 && w_rs2 != 5'd0) begin
      w_rd2 = io_bus.resultW;
    end
  end

  always_comb begin
    unique case (w_f3)
      3'b000:  w_alu_f3 = AluAdd;
      3'b001:  w_alu_f3 = AluSll;
      3'b010:  w_alu_f3 = AluSlt;
      3'b011:  w_alu_f3 = AluSltu;
      3'b100:  w_alu_f3 = AluXor;
      3'b101:  w_alu_f3 = AluSrl;
      3'b110:  w_alu_f3 = AluOr;
      default: w_alu_f3 = AluAnd;
    endcase
  end

  always_comb begin
    w_dec        = '0;
    w_dec.valid  = io_bus.validD;
    w_dec.funct3 = w_f3;
    w_dec.rd     = w_rd;
    w_dec.rs1    = w_rs1;
    w_dec.rs2    = w_rs2;
    w_dec.rd1    = w_rd1;
    w_dec.rd2    = w_rd2;
    w_dec.pc     = io_bus.pcD;
    w_dec.pc4    = io_bus.pc4D;
    w_imm32      = {{20{w_instr[31]}}, w_instr[31:20]};
    w_use_rd     = 1'b0;
    w_use_rs1    = 1'b0;
    w_use_rs2    = 1'b0;

    case (w_op)
      OpReg: begin
        {w_use_rd, w_use_rs1, w_use_rs2} = 3'b111;
        w_dec.regwrite = 1'b1;
        w_dec.wbsel    = 2'b01;
        w_dec.alusel   = w_alu_f3;
        if (w_f7 == 7'b0100000) begin
          if (w_f3 == 3'b000)      w_dec.alusel  = AluSub;
          else if (w_f3 == 3'b101) w_dec.alusel  = AluSra;
          else                     w_dec.illegal = 1'b1;
        end else if (w_f7 != 7'b0000000) begin
          w_dec.illegal = 1'b1;
        end
      end
      OpImm: begin
        {w_use_rd, w_use_rs1} = 2'b11;
        w_dec.regwrite = 1'b1;
        w_dec.bsel     = 1'b1;
        w_dec.wbsel    = 2'b01;
        w_dec.alusel   = w_alu_f3;
        if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
          // Shifts carry only the shamt; imm[11:5] is a function code here.
          w_imm32 = {27'b0, w_instr[24:20]};
          if (w_f3 == 3'b101 && w_f7 == 7'b0100000) w_dec.alusel  = AluSra;
          else if (w_f7 != 7'b0000000)              w_dec.illegal = 1'b1;
        end
      end
      OpLoad: begin
        {w_use_rd, w_use_rs1} = 2'b11;
        w_dec.regwrite = 1'b1;
        w_dec.bsel     = 1'b1;
        w_dec.illegal  = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11);
      end
      OpStore: begin
        {w_use_rs1, w_use_rs2} = 2'b11;
        w_imm32       = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
        w_dec.memrw   = 1'b1;
        w_dec.bsel    = 1'b1;
        w_dec.illegal = w_f3[2] || (w_f3 == 3'b011);
      end
      OpBr: begin
        {w_use_rs1, w_use_rs2} = 2'b11;
        w_imm32 = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                   w_instr[11:8], 1'b0};
        w_dec.branch  = 1'b1;
        w_dec.asel    = 1'b1;
        w_dec.bsel    = 1'b1;
        w_dec.brun    = (w_f3[2:1] == 2'b11);
        w_dec.illegal = (w_f3[2:1] == 2'b01);
      end
      OpJal: begin
        w_use_rd = 1'b1;
        w_imm32  = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                    w_instr[30:21], 1'b0};
        w_dec.asel     = 1'b1;
        w_dec.bsel     = 1'b1;
        w_dec.jump     = 1'b1;
        w_dec.wbsel    = 2'b10;
        w_dec.regwrite = 1'b1;
      end
      OpJalr: begin
        {w_use_rd, w_use_rs1} = 2'b11;
        w_dec.bsel     = 1'b1;
        w_dec.jump     = 1'b1;
        w_dec.wbsel    = 2'b10;
        w_dec.regwrite = 1'b1;
        w_dec.illegal  = (w_f3 != 3'b000);
      end
      OpLui, OpAuipc: begin
        w_use_rd       = 1'b1;
        w_imm32        = {w_instr[31:12], 12'b0};
        w_dec.asel     = (w_op == OpAuipc);
        w_dec.bsel     = 1'b1;
        w_dec.alusel   = (w_op == OpLui) ? AluPassB : AluAdd;
        w_dec.wbsel    = 2'b01;
        w_dec.regwrite = 1'b1;
      end
      default: w_dec.illegal = 1'b1;
    endcase

    if (RV32E && ((w_use_rd && w_rd[4]) || (w_use_rs1 && w_rs1[4]) ||
                  (w_use_rs2 && w_rs2[4]))) begin
      w_dec.illegal = 1'b1;
    end

    w_dec.imm = {{(XLEN-31){w_imm32[31]}}, w_imm32[30:0]};

    if (w_dec.illegal) begin
      w_dec.regwrite = 1'b0;
      w_dec.memrw    = 1'b0;
      w_dec.branch   = 1'b0;
      w_dec.jump     = 1'b0;
    end

    if (!io_bus.validD) begin
      w_dec.illegal  = 1'b0;
      w_dec.regwrite = 1'b0;
      w_dec.memrw    = 1'b0;
      w_dec.brun     = 1'b0;
      w_dec.branch   = 1'b0;
      w_dec.jump     = 1'b0;
      w_dec.asel     = 1'b0;
      w_dec.bsel     = 1'b0;
      w_dec.wbsel    = 2'b00;
      w_dec.alusel   = AluAdd;
    end
  end

  // A stall holds rd1/rd2 as captured; EX forwarding covers later writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex <= '0;
    end else if (io_bus.flushE) begin
      r_ex <= '0;
    end else if (!io_bus.stallD) begin
      r_ex <= w_dec;
    end
  end

  assign io_bus.validE    = r_ex.valid;
  assign io_bus.illegalE  = r_ex.illegal;
  assign io_bus.regwriteE = r_ex.regwrite;
  assign io_bus.memrwE    = r_ex.memrw;
  assign io_bus.brunE     = r_ex.brun;
  assign io_bus.branchE   = r_ex.branch;
  assign io_bus.jumpE     = r_ex.jump;
  assign io_bus.aselE     = r_ex.asel;
  assign io_bus.bselE     = r_ex.bsel;
  assign io_bus.wbselE    = r_ex.wbsel;
  assign io_bus.ALUselE   = r_ex.alusel;
  assign io_bus.funct3E   = r_ex.funct3;
  assign io_bus.rdE       = r_ex.rd;
  assign io_bus.rs1E      = r_ex.rs1;
  assign io_bus.rs2E      = r_ex.rs2;
  assign io_bus.rd1E      = r_ex.rd1;
  assign io_bus.rd2E      = r_ex.rd2;
  assign io_bus.imm_exE   = r_ex.imm;
  assign io_bus.pcE       = r_ex.pc;
  assign io_bus.pc4E      = r_ex.pc4;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: decode table plus bypass, RV32E,
// stall/flush and mid-stream reset sequences.
module tb_rv_decode_stage;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [13:0] M_ALL = 14'h3FFF;
  localparam logic [13:0] M_IL  = 14'b11101100000000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  rv_decode_stage_if #(.XLEN(32)) bus ();
  rv_decode_stage_if #(.XLEN(32)) bus2 ();

  rv_decode_stage #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .io_bus(bus)
  );
  rv_decode_stage #(.XLEN(32), .NREGS(16), .BYPASS(1'b0)) dut_e (
    .clk(clk), .rst_n(rst_n), .io_bus(bus2)
  );

  assign bus2.validD    = bus.validD;
  assign bus2.stallD    = bus.stallD;
  assign bus2.flushE    = bus.flushE;
  assign bus2.regwriteW = bus.regwriteW;
  assign bus2.rdW       = bus.rdW;
  assign bus2.resultW   = bus.resultW;
  assign bus2.instrD    = bus.instrD;
  assign bus2.pcD       = bus.pcD;
  assign bus2.pc4D      = bus.pc4D;

  logic [13:0] act_ctl;
  logic        any_e, any_e2;
  assign act_ctl = {bus.illegalE, bus.regwriteE, bus.memrwE, bus.brunE, bus.branchE,
                    bus.jumpE, bus.aselE, bus.bselE, bus.wbselE, bus.ALUselE};
  assign any_e  = |{bus.validE, act_ctl, bus.funct3E, bus.rdE, bus.rs1E, bus.rs2E,
                    bus.rd1E, bus.rd2E, bus.imm_exE, bus.pcE, bus.pc4E};
  assign any_e2 = |{bus2.validE, bus2.illegalE, bus2.regwriteE, bus2.memrwE, bus2.rd1E,
                    bus2.rd2E, bus2.imm_exE, bus2.pcE, bus2.pc4E};

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        valid;
    logic [13:0] ctl;
    logic [13:0] mask;
    logic        chk_imm;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction
  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [6:0] op);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
  endfunction
  function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rd, logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd, logic [6:0] op);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
  endfunction

  // Order: illegal, regwrite, memrw, brun, branch, jump, asel, bsel, wbsel, alusel.
  function automatic logic [13:0] c(logic il, logic rw, logic mw, logic bu, logic br,
                                    logic j, logic a, logic b, logic [1:0] wb,
                                    logic [3:0] alu);
    return {il, rw, mw, bu, br, j, a, b, wb, alu};
  endfunction

  function automatic vec_t mkv(string n, logic [31:0] ins, logic v, logic [13:0] ctl,
                               logic [13:0] m, logic ci, logic [31:0] im);
    vec_t r;
    r.name = n; r.instr = ins; r.valid = v; r.ctl = ctl; r.mask = m;
    r.chk_imm = ci; r.imm = im;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic v);
    bus.instrD = ins;
    bus.validD = v;
  endtask

  initial begin
    bus.validD = 0; bus.stallD = 0; bus.flushE = 0; bus.regwriteW = 0;
    bus.rdW = 0; bus.resultW = 0; bus.instrD = 0; bus.pcD = 0; bus.pc4D = 0;

    vecs.push_back(mkv("add", enc_r(7'h00, 3, 2, 0, 1, OP_R), 1,
                       c(0,1,0,0,0,0,0,0,2'b01,0), M_ALL, 0, 0));
    vecs.push_back(mkv("sub", enc_r(7'h20, 3, 2, 0, 1, OP_R), 1,
                       c(0,1,0,0,0,0,0,0,2'b01,1), M_ALL, 0, 0));
    vecs.push_back(mkv("sra", enc_r(7'h20, 3, 2, 5, 1, OP_R), 1,
                       c(0,1,0,0,0,0,0,0,2'b01,7), M_ALL, 0, 0));
    vecs.push_back(mkv("sltu", enc_r(7'h00, 3, 2, 3, 1, OP_R), 1,
                       c(0,1,0,0,0,0,0,0,2'b01,9), M_ALL, 0, 0));
    vecs.push_back(mkv("and", enc_r(7'h00, 3, 2, 7, 1, OP_R), 1,
                       c(0,1,0,0,0,0,0,0,2'b01,2), M_ALL, 0, 0));
    vecs.push_back(mkv("r_f7_bad", enc_r(7'h20, 3, 2, 7, 1, OP_R), 1,
                       c(1,0,0,0,0,0,0,0,2'b00,0), M_IL, 0, 0));
    vecs.push_back(mkv("srai", enc_i({7'h20, 5'd3}, 4, 5, 3, OP_I), 1,
                       c(0,1,0,0,0,0,0,1,2'b01,7), M_ALL, 1, 32'd3));
    vecs.push_back(mkv("slli_bad", enc_i({7'h01, 5'd3}, 4, 1, 3, OP_I), 1,
                       c(1,0,0,0,0,0,0,0,2'b00,0), M_IL, 0, 0));
    vecs.push_back(mkv("srli_bad", enc_i({7'h10, 5'd2}, 4, 5, 3, OP_I), 1,
                       c(1,0,0,0,0,0,0,0,2'b00,0), M_IL, 0, 0));
    vecs.push_back(mkv("addi_m1", enc_i(12'hFFF, 0, 0, 1, OP_I), 1,
                       c(0,1,0,0,0,0,0,1,2'b01,0), M_ALL, 1, 32'hFFFF_FFFF));
    vecs.push_back(mkv("slti", enc_i(12'd5, 2, 2, 1, OP_I), 1,
                       c(0,1,0,0,0,0,0,1,2'b01,8), M_ALL, 1, 32'd5));
    vecs.push_back(mkv("lw", enc_i(12'd8, 1, 2, 5, OP_LD), 1,
                       c(0,1,0,0,0,0,0,1,2'b00,0), M_ALL, 1, 32'd8));
    vecs.push_back(mkv("ld_bad", enc_i(12'd8, 1, 3, 5, OP_LD), 1,
                       c(1,0,0,0,0,0,0,0,2'b00,0), M_IL, 0, 0));
    vecs.push_back(mkv("sw", enc_s(12'hFFC, 2, 1, 2, OP_ST), 1,
                       c(0,0,1,0,0,0,0,1,2'b00,0), M_ALL, 1, 32'hFFFF_FFFC));
    vecs.push_back(mkv("st_bad", enc_s(12'd4, 2, 1, 4, OP_ST), 1,
                       c(1,0,0,0,0,0,0,0,2'b00,0), M_IL, 0, 0));
    vecs.push_back(mkv("bltu", enc_b(13'd16, 2, 1, 6, OP_BR), 1,
                       c(0,0,0,1,1,0,1,1,2'b00,0), M_ALL, 1, 32'd16));
    vecs.push_back(mkv("beq", enc_b(13'h1FF8, 2, 1, 0, OP_BR), 1,
                       c(0,0,0,0,1,0,1,1,2'b00,0), M_ALL, 1, 32'hFFFF_FFF8));
    vecs.push_back(mkv("br_bad", enc_b(13'd16, 2, 1, 2, OP_BR), 1,
                       c(1,0,0,0,0,0,0,0,2'b00,0), M_IL, 0, 0));
    vecs.push_back(mkv("jal", enc_j(21'd8, 1, OP_JAL), 1,
                       c(0,1,0,0,0,1,1,1,2'b10,0), M_ALL, 1, 32'd8));
    vecs.push_back(mkv("jalr", enc_i(12'd4, 2, 0, 1, OP_JALR), 1,
                       c(0,1,0,0,0,1,0,1,2'b10,0), M_ALL, 1, 32'd4));
    vecs.push_back(mkv("jalr_bad", enc_i(12'd4, 2, 1, 1, OP_JALR), 1,
                       c(1,0,0,0,0,0,0,0,2'b00,0), M_IL, 0, 0));
    vecs.push_back(mkv("lui", enc_u(20'h80000, 2, OP_LUI), 1,
                       c(0,1,0,0,0,0,0,1,2'b01,10), M_ALL, 1, 32'h8000_0000));
    vecs.push_back(mkv("auipc", enc_u(20'h00001, 3, OP_AUIPC), 1,
                       c(0,1,0,0,0,0,1,1,2'b01,0), M_ALL, 1, 32'h0000_1000));
    vecs.push_back(mkv("fence_op", {25'h0, 7'b0001111}, 1,
                       c(1,0,0,0,0,0,0,0,2'b00,0), M_IL, 0, 0));
    vecs.push_back(mkv("not_valid", enc_r(7'h00, 3, 2, 0, 1, OP_R), 0,
                       c(0,0,0,0,0,0,0,0,2'b00,0), M_ALL, 0, 0));

    // Reset state
    #12;
    check("reset_all_zero", 32'(any_e), 0);
    check("reset_all_zero_e", 32'(any_e2), 0);
    #10 rst_n = 1'b1;
    step();

    // Bypass: write x5 while reading it
    bus.regwriteW = 1; bus.rdW = 5; bus.resultW = 32'hDEAD_BEEF;
    drive(enc_r(7'h00, 5, 5, 0, 1, OP_R), 1);
    step();
    check("bypass_rd1", bus.rd1E, 32'hDEAD_BEEF);
    check("bypass_rd2", bus.rd2E, 32'hDEAD_BEEF);
    check("nobypass_rd1", bus2.rd1E, 32'h0);
    bus.regwriteW = 1; bus.rdW = 6; bus.resultW = 32'hCAFE_0006;
    step();
    check("nobypass_after_wr", bus2.rd1E, 32'hDEAD_BEEF);
    bus.regwriteW = 1; bus.rdW = 0; bus.resultW = 32'h1234_5678;
    drive(enc_r(7'h00, 0, 0, 0, 1, OP_R), 1);
    step();
    check("x0_bypass", bus.rd1E, 32'h0);
    bus.regwriteW = 0;
    drive(enc_r(7'h00, 6, 0, 0, 1, OP_R), 1);
    step();
    check("x0_read", bus.rd1E, 32'h0);
    check("x6_read", bus.rd2E, 32'hCAFE_0006);

    // Decode table
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].instr, vecs[i].valid);
      step();
      check({vecs[i].name, "_ctl"}, 32'(act_ctl & vecs[i].mask),
            32'(vecs[i].ctl & vecs[i].mask));
      check({vecs[i].name, "_valid"}, 32'(bus.validE), 32'(vecs[i].valid));
      if (vecs[i].chk_imm) check({vecs[i].name, "_imm"}, bus.imm_exE, vecs[i].imm);
    end

    // RV32E register range
    drive(enc_i(12'd1, 0, 0, 17, OP_I), 1);
    step();
    check("e_rd17_illegal", 32'(bus2.illegalE), 1);
    check("e_rd17_regwrite", 32'(bus2.regwriteE), 0);
    check("i_rd17_legal", 32'(bus.illegalE), 0);
    drive(enc_r(7'h00, 20, 2, 0, 1, OP_R), 1);
    step();
    check("e_rs2_20_illegal", 32'(bus2.illegalE), 1);
    drive(enc_i(12'd1, 0, 0, 7, OP_I), 1);
    step();
    check("e_rd7_legal", 32'({bus2.illegalE, bus2.regwriteE}), 32'b01);

    // Stall then flush
    drive(enc_s(12'hFFC, 6, 5, 2, OP_ST), 1);
    bus.pcD = 32'h100; bus.pc4D = 32'h104;
    step();
    check("sw_capture", 32'({bus.validE, bus.memrwE, bus.regwriteE}), 32'b110);
    check("sw_rd1", bus.rd1E, 32'hDEAD_BEEF);
    check("sw_rd2", bus.rd2E, 32'hCAFE_0006);
    check("sw_pc4", bus.pc4E, 32'h104);
    for (int k = 0; k < 3; k++) begin
      bus.stallD = 1;
      drive(enc_r(7'h00, 3, 2, 0, 7 + k, OP_R), 1);
      bus.pcD = 32'h200 + 32'(k);
      bus.regwriteW = (k == 0); bus.rdW = 5; bus.resultW = 32'h1111_1111;
      if (k == 1) begin bus.regwriteW = 1; bus.rdW = 7; bus.resultW = 32'h77; end
      step();
      check("stall_ctl", 32'({bus.validE, bus.memrwE, bus.regwriteE}), 32'b110);
      check("stall_rd1", bus.rd1E, 32'hDEAD_BEEF);
      check("stall_fields", {bus.imm_exE[15:0], bus.pcE[15:0]}, 32'hFFFC_0100);
      check("stall_rs", 32'({bus.rs1E, bus.rs2E, bus.funct3E}), 32'({5'd5, 5'd6, 3'd2}));
    end
    bus.stallD = 1; bus.flushE = 1;
    bus.regwriteW = 1; bus.rdW = 5; bus.resultW = 32'h5555_5555;
    step();
    check("flush_bubble", 32'({bus.validE, bus.memrwE}), 0);
    check("flush_all_zero", 32'(any_e), 0);
    bus.stallD = 0; bus.flushE = 0; bus.regwriteW = 0;
    drive(enc_r(7'h00, 7, 5, 0, 1, OP_R), 1);
    step();
    check("wr_in_flush", bus.rd1E, 32'h5555_5555);
    check("wr_in_stall", bus.rd2E, 32'h77);

    // Mid-stream asynchronous reset
    drive(enc_i(12'd8, 1, 2, 5, OP_LD), 1);
    step();
    check("pre_reset_valid", 32'(bus.validE), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_zero", 32'(any_e), 0);
    check("async_reset_zero_e", 32'(any_e2), 0);
    #2 rst_n = 1'b1;
    drive(enc_r(7'h00, 5, 5, 0, 1, OP_R), 1);
    step();
    check("post_reset_x5", bus.rd1E, 32'h0);
    check("post_reset_valid", 32'(bus.validE), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
